captura_codigo: RTL and testbench
=================================

// Module: captura_codigo
// PURPOSE
//  Parametrised N-digit product-code entry controller for the vending machine keypad path.
//  - Generalises the two-digit row/column capture to NUM_DIGITOS digits.
//  - Captures debounced keypad digits into an internal code register with an inter-digit timeout.
//  - Holds the completed code until the dispenser acknowledges with ok.
//  - Sits between the keypad decoder and the price/dispense logic.
// PARAMETERS
//  NUM_DIGITOS     3    digits per product code (>=1)
//  DIGITO_W        4    bits per digit
//  TIMEOUT_CICLOS  1000 clk cycles allowed between accepted digits before abandoning entry (>=2)
// PORTS
//  clk            in   1                      system clock, rising edge
//  rst_n          in   1                      asynchronous active-low reset
//  digito_valido  in   1                      one-cycle strobe: digito holds a new key
//  digito         in   DIGITO_W               key value, sampled only with digito_valido
//  ok             in   1                      dispenser acknowledge, releases BLOQUEADO
//  cancelar       in   1                      abort entry from any state
//  apagar         in   1                      backspace (used only with CAPTURA_APAGAR_EN)
//  codigo         out  NUM_DIGITOS*DIGITO_W   captured code, digit 0 in LSBs
//  en_digito      out  NUM_DIGITOS            one-hot pulse, bit i = digit i just written
//  indice         out  max(1,clog2(NUM_DIGITOS))  index of next digit to be written
//  codigo_valido  out  1                      high while in BLOQUEADO
//  clear          out  1                      high while in ESPERA (downstream clear)
//  timeout        out  1                      one-cycle pulse when entry abandoned by timer
// BEHAVIOUR
//  - All outputs registered. Reset (rst_n=0, async): state ESPERA, codigo=0, en_digito=0,
//    indice=0, codigo_valido=0, clear=1, timeout=0, timer=0.
//  - States: ESPERA, CAPTURA, BLOQUEADO (2-bit encoding, unused code -> ESPERA).
//  - Priority each cycle: cancelar > apagar > digito_valido > timer expiry; ok only in BLOQUEADO.
//  - ESPERA: digito_valido -> write digit 0, indice=1, timer=0;
//    go CAPTURA, or straight to BLOQUEADO if NUM_DIGITOS==1.
//  - CAPTURA:
//    - digito_valido -> write digit[indice], timer=0, indice+1.
//    - Writing digit NUM_DIGITOS-1 -> BLOQUEADO; indice wraps to 0.
//    - Timer counts every cycle without an accepted digit.
//    - At TIMEOUT_CICLOS-1 -> ESPERA, timeout pulse, codigo=0.
//    - A digit arriving in the expiry cycle is accepted; the timer restarts.
//  - BLOQUEADO:
//    - digito_valido ignored; timer held at 0.
//    - ok -> ESPERA, codigo=0.
//  - cancelar (any state) -> ESPERA next cycle, codigo=0, indice=0, timer=0, no timeout pulse.
//  - en_digito: bit i high for exactly the cycle codigo first shows the new digit i
//    (one cycle after the strobe).
//  - clear and codigo_valido are level outputs decoded from the registered state.
//  - Mid-entry rst_n assertion discards partial code immediately (async).
//  - Timer width clog2(TIMEOUT_CICLOS); it never wraps (saturates at expiry).
// CONFIGURATION
//  CAPTURA_APAGAR_EN defined:
//    - apagar in CAPTURA with indice>1 -> indice-1, that digit zeroed, timer=0.
//    - apagar in CAPTURA with indice==1 -> ESPERA, codigo=0.
//    - apagar in BLOQUEADO -> CAPTURA, last digit zeroed, indice=NUM_DIGITOS-1, timer=0.
//    - apagar in ESPERA ignored. No en_digito pulse on erase.
//  CAPTURA_APAGAR_EN undefined:
//    - apagar port present but ignored; no erase logic synthesised.
// TESTING (NUM_DIGITOS=3, DIGITO_W=4, TIMEOUT_CICLOS=10)
//  - Reset, then keys 4,7,2 spaced 3 cycles -> codigo=12'h274, en_digito pulses 001,010,100,
//    codigo_valido=1, clear=0; ok -> clear=1, codigo=0 next cycle.
//  - Key 5, then idle 10 cycles -> timeout pulse once, ESPERA, codigo=0, indice=0.
//  - Key 5 then key 6 exactly in the expiry cycle -> accepted, codigo=12'h065, no timeout.
//  - In BLOQUEADO (code 12'h321), key 9 -> codigo unchanged; cancelar mid-entry after 1 key -> ESPERA,
//    no timeout pulse.
//  - rst_n low for 1 cycle between key 2 and key 3 -> all outputs at reset values asynchronously.
//  - CAPTURA_APAGAR_EN: keys 1,2, apagar, 8, 3 -> codigo=12'h381; undefined build: same
//    stimulus -> codigo=12'h821 (apagar ignored; the 3 is ignored in BLOQUEADO).

Source files
------------

// File: rtl/captura_codigo.sv
// N-digit keypad code capture with inter-digit timeout; holds the code until ok. Optional erase via CAPTURA_APAGAR_EN.
// Latency: one cycle from digito_valido/ok/cancelar/apagar to registered outputs.
// Backpressure: none; digit strobes arriving while the code is held are dropped.
module captura_codigo #(
    parameter int NUM_DIGITOS    = 3,
    parameter int DIGITO_W       = 4,
    parameter int TIMEOUT_CICLOS = 1000,
    localparam int IDX_W = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1,
    localparam int TMR_W = $clog2(TIMEOUT_CICLOS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            digito_valido,
    input  logic [DIGITO_W-1:0]             digito,
    input  logic                            ok,
    input  logic                            cancelar,
    input  logic                            apagar,
    output logic [NUM_DIGITOS*DIGITO_W-1:0] codigo,
    output logic [NUM_DIGITOS-1:0]          en_digito,
    output logic [IDX_W-1:0]                indice,
    output logic                            codigo_valido,
    output logic                            clear,
    output logic                            timeout
);

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        CAPTURA   = 2'd1,
        BLOQUEADO = 2'd2
    } estado_t;

    localparam logic [IDX_W-1:0] ULTIMO  = IDX_W'(NUM_DIGITOS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CICLOS - 1);

    estado_t          estado;
    logic [TMR_W-1:0] timer;

`ifndef CAPTURA_APAGAR_EN
    logic unusedApagar;
    assign unusedApagar = apagar;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= ESPERA;
            codigo        <= '0;
            en_digito     <= '0;
            indice        <= '0;
            codigo_valido <= 1'b0;
            clear         <= 1'b1;
            timeout       <= 1'b0;
            timer         <= '0;
        end else begin
            en_digito <= '0;
            timeout   <= 1'b0;
            if (cancelar) begin
                estado        <= ESPERA;
                codigo        <= '0;
                indice        <= '0;
                codigo_valido <= 1'b0;
                clear         <= 1'b1;
                timer         <= '0;
            end
`ifdef CAPTURA_APAGAR_EN
            else if (apagar && estado == CAPTURA) begin
                timer <= '0;
                if (indice > IDX_W'(1)) begin
                    indice <= indice - 1'b1;
                    codigo[(int'(indice) - 1)*DIGITO_W +: DIGITO_W] <= '0;
                end else begin
                    // Erasing the only digit abandons the entry.
                    estado <= ESPERA;
                    codigo <= '0;
                    indice <= '0;
                    clear  <= 1'b1;
                end
            end else if (apagar && estado == BLOQUEADO) begin
                estado        <= CAPTURA;
                codigo[(NUM_DIGITOS-1)*DIGITO_W +: DIGITO_W] <= '0;
                indice        <= ULTIMO;
                codigo_valido <= 1'b0;
                timer         <= '0;
            end
`endif
            else if (digito_valido && (estado == ESPERA || estado == CAPTURA)) begin
                // In ESPERA indice is already 0, so both states share the write path.
                codigo[int'(indice)*DIGITO_W +: DIGITO_W] <= digito;
                en_digito[indice] <= 1'b1;
                timer             <= '0;
                clear             <= 1'b0;
                if (indice == ULTIMO) begin
                    estado        <= BLOQUEADO;
                    indice        <= '0;
                    codigo_valido <= 1'b1;
                end else begin
                    estado <= CAPTURA;
                    indice <= indice + 1'b1;
                end
            end else begin
                case (estado)
                    ESPERA: begin
                        timer <= '0;
                    end
                    CAPTURA: begin
                        if (timer == TMR_MAX) begin
                            estado  <= ESPERA;
                            codigo  <= '0;
                            indice  <= '0;
                            clear   <= 1'b1;
                            timeout <= 1'b1;
                            timer   <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    BLOQUEADO: begin
                        timer <= '0;
                        if (ok) begin
                            estado        <= ESPERA;
                            codigo        <= '0;
                            codigo_valido <= 1'b0;
                            clear         <= 1'b1;
                        end
                    end
                    default: begin
                        estado        <= ESPERA;
                        codigo        <= '0;
                        indice        <= '0;
                        codigo_valido <= 1'b0;
                        clear         <= 1'b1;
                        timer         <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_captura_codigo.sv
// Randomised and directed bench for captura_codigo against a queue-based model of the entered digits.
module tb_captura_codigo;
    localparam int N = 3;
    localparam int W = 4;
    localparam int T = 10;
`ifdef CAPTURA_APAGAR_EN
    localparam bit APAGAR = 1'b1;
`else
    localparam bit APAGAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         digitoValido = 1'b0;
    logic [W-1:0] digito = '0;
    logic         ok = 1'b0;
    logic         cancelar = 1'b0;
    logic         apagar = 1'b0;
    logic [N*W-1:0] codigo;
    logic [N-1:0] enDigito;
    logic [1:0]   indice;
    logic         codigoValido;
    logic         clear;
    logic         timeout;

    int total = 0;
    int bad = 0;
    int nTimeouts = 0;

    // Model: digits entered so far, lock flag, idle cycles since last accepted digit.
    int digs[$];
    bit bloq = 1'b0;
    int ocioso = 0;
    int pulso = -1;
    bit toEsp = 1'b0;

    always #5 clk = ~clk;

    captura_codigo #(
        .NUM_DIGITOS(N),
        .DIGITO_W(W),
        .TIMEOUT_CICLOS(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .digito_valido(digitoValido),
        .digito(digito),
        .ok(ok),
        .cancelar(cancelar),
        .apagar(apagar),
        .codigo(codigo),
        .en_digito(enDigito),
        .indice(indice),
        .codigo_valido(codigoValido),
        .clear(clear),
        .timeout(timeout)
    );

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, esp, $time);
        end
    endtask

    task automatic modeloReset();
        digs.delete();
        bloq = 1'b0;
        ocioso = 0;
        pulso = -1;
        toEsp = 1'b0;
    endtask

    task automatic modeloPaso();
        pulso = -1;
        toEsp = 1'b0;
        if (cancelar) begin
            digs.delete();
            bloq = 1'b0;
            ocioso = 0;
        end else if (APAGAR && apagar && digs.size() > 0) begin
            void'(digs.pop_back());
            bloq = 1'b0;
            ocioso = 0;
        end else if (digitoValido && !bloq) begin
            digs.push_back(int'(digito));
            pulso = digs.size() - 1;
            ocioso = 0;
            if (digs.size() == N) bloq = 1'b1;
        end else if (!bloq && digs.size() > 0) begin
            if (ocioso == T - 1) begin
                digs.delete();
                toEsp = 1'b1;
                ocioso = 0;
            end else begin
                ocioso++;
            end
        end else if (bloq && ok) begin
            digs.delete();
            bloq = 1'b0;
        end
    endtask

    task automatic revisar();
        logic [31:0] c;
        logic [31:0] e;
        c = '0;
        foreach (digs[i]) c = c | (32'(digs[i]) << (W * i));
        e = (pulso >= 0) ? (32'd1 << pulso) : 32'd0;
        chequear("codigo", 32'(codigo), c);
        chequear("en_digito", 32'(enDigito), e);
        chequear("indice", 32'(indice), bloq ? 32'd0 : 32'(digs.size()));
        chequear("codigo_valido", 32'(codigoValido), 32'(bloq));
        chequear("clear", 32'(clear), 32'(!bloq && digs.size() == 0));
        chequear("timeout", 32'(timeout), 32'(toEsp));
    endtask

    task automatic paso(input bit dv, input int d, input bit k, input bit cn, input bit ap);
        digitoValido = dv;
        digito = W'(d);
        ok = k;
        cancelar = cn;
        apagar = ap;
        @(posedge clk);
        modeloPaso();
        @(negedge clk);
        if (timeout) nTimeouts++;
        revisar();
    endtask

    task automatic ocio(input int n);
        repeat (n) paso(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tecla(input int d);
        paso(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pDig;
        modeloReset();
        repeat (2) @(negedge clk);
        revisar();
        rst_n = 1'b1;

        // Three keys spaced three cycles, then release with ok.
        tecla(4); ocio(2); tecla(7); ocio(2); tecla(2);
        chequear("codigo_274", 32'(codigo), 32'h274);
        chequear("valido_274", 32'(codigoValido), 32'd1);
        chequear("clear_274", 32'(clear), 32'd0);
        paso(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chequear("codigo_tras_ok", 32'(codigo), 32'd0);
        chequear("clear_tras_ok", 32'(clear), 32'd1);

        // Single key abandoned by the timer.
        nTimeouts = 0;
        tecla(5); ocio(12);
        chequear("timeout_unico", 32'(nTimeouts), 32'd1);
        chequear("indice_tras_to", 32'(indice), 32'd0);

        // Second key lands exactly in the expiry cycle.
        nTimeouts = 0;
        tecla(5); ocio(9); tecla(6);
        chequear("codigo_065", 32'(codigo), 32'h065);
        chequear("sin_timeout_065", 32'(nTimeouts), 32'd0);
        paso(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Key ignored while held; cancel mid-entry.
        tecla(1); tecla(2); tecla(3); tecla(9);
        chequear("codigo_321", 32'(codigo), 32'h321);
        paso(1'b0, 0, 1'b1, 1'b0, 1'b0);
        nTimeouts = 0;
        tecla(1); paso(1'b0, 0, 1'b0, 1'b1, 1'b0); ocio(12);
        chequear("cancelar_sin_to", 32'(nTimeouts), 32'd0);
        chequear("cancelar_clear", 32'(clear), 32'd1);

        // Asynchronous reset between second and third key.
        tecla(1); tecla(2);
        rst_n = 1'b0;
        #1;
        chequear("rst_codigo", 32'(codigo), 32'd0);
        chequear("rst_indice", 32'(indice), 32'd0);
        chequear("rst_clear", 32'(clear), 32'd1);
        chequear("rst_valido", 32'(codigoValido), 32'd0);
        chequear("rst_en", 32'(enDigito), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        modeloReset();
        tecla(3);
        chequear("tras_rst", 32'(codigo), 32'h003);
        paso(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Erase sequence.
        tecla(1); tecla(2); paso(1'b0, 0, 1'b0, 1'b0, 1'b1); tecla(8); tecla(3);
        chequear("codigo_apagar", 32'(codigo), APAGAR ? 32'h381 : 32'h821);
        paso(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Random traffic, alternating dense and sparse keying to reach the timer.
        for (int blk = 0; blk < 16; blk++) begin
            pDig = (blk % 2 == 1) ? 40 : 4;
            repeat (200) begin
                paso($urandom_range(0, 99) < pDig,
                     int'($urandom_range(0, 15)),
                     $urandom_range(0, 99) < 10,
                     $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 6);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
